// File: rtl/canvas_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | canvas_scheduler: shares the single canvas port among pen, recognizer, clear.  |
// | Rev 1.0                                                                        |
// +--------------------------------------------------------------------------------+
module canvas_scheduler #(
  parameter int ADDR_W   = 10,
  parameter int RESULT_W = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                clr,
  input  logic                pen_we,
  input  logic [ADDR_W-1:0]   pen_addr,
  input  logic                pen_data,
  output logic                pen_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic                mem_wdata,
  output logic                mem_re,
  input  logic                mem_rdata,
  output logic                rec_start,
  input  logic [ADDR_W-1:0]   rec_read_addr,
  input  logic                rec_read_enable,
  output logic                rec_read_data,
  input  logic                rec_result_valid,
  input  logic [RESULT_W-1:0] rec_result,
  output logic                busy,
  output logic                result_valid,
  output logic [RESULT_W-1:0] result,
  output logic                error
);

  localparam int C_TO_W = $clog2(TIMEOUT);
  localparam int CNT_W  = (C_TO_W > ADDR_W) ? C_TO_W : ADDR_W;
  localparam logic [CNT_W-1:0] C_LAST_ADDR = CNT_W'((2 ** ADDR_W) - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    SCAN  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                clr_pend_q, clr_pend_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    clr_pend_d   = clr_pend_q | (clr && (state_q != IDLE));
    pen_ready    = 1'b0;
    mem_addr     = pen_addr;
    mem_we       = 1'b0;
    mem_wdata    = pen_data;
    mem_re       = 1'b0;
    rec_start    = 1'b0;
    result_valid = 1'b0;
    error        = 1'b0;

    case (state_q)
      IDLE: begin
        pen_ready = 1'b1;
        mem_we    = pen_we;
        // A clear always wins over a recognition request issued alongside it.
        if (clr_pend_q || clr) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_pend_d = 1'b0;
        end else if (req) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = 1'b0;
        mem_addr  = cnt_q[ADDR_W-1:0];
        if (cnt_q == C_LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      START: begin
        rec_start = 1'b1;
        mem_addr  = rec_read_addr;
        mem_re    = rec_read_enable;
        cnt_d     = cnt_q + C_ONE;
        state_d   = SCAN;
      end
      SCAN: begin
        mem_addr = rec_read_addr;
        mem_re   = rec_read_enable;
        // cnt tracks the scan address, so the last address ends the scan cleanly.
        if (cnt_q == C_LAST_ADDR) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (!rec_read_enable) begin
          error   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      WAIT: begin
        if (rec_result_valid) begin
          result_d = rec_result;
          state_d  = DONE;
        end else if (cnt_q == C_TO_LAST) begin
          error   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rec_read_data = mem_rdata;
  assign busy          = (state_q != IDLE);
  assign result        = result_q;

endmodule
`default_nettype wire
